eat_sequencer: RTL and testbench

//  Drives the eat layer's control inputs: ActionS, run, DogPos_x1, DogPos_x2 and DogPos_y.
//  On an eat request it runs one complete eat scene. WALK lowers the dog from START_Y to EAT_Y,

---
 rtl/eat_seq_pkg.sv | 15 +
 rtl/eat_pose_timer.sv | 44 ++++
 rtl/eat_sequencer.sv | 144 ++++++++++++++
 tb/tb_eat_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/eat_seq_pkg.sv
// Shared types and widths for the eat-scene sequencer and its pose timer.
package eat_seq_pkg;
  localparam int TILE_W = 64;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;
  localparam int CNT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WALK,
    S_EAT,
    S_RETURN,
    S_DONE
  } state_t;
endpackage

// File: rtl/eat_pose_timer.sv
// Counts frame ticks inside EAT; flags each pose flip and the final flip of the scene.
module eat_pose_timer
  import eat_seq_pkg::*;
#(
  parameter int unsigned FRAMES_PER_POSE = 8,
  parameter int unsigned EAT_FLIPS       = 6
) (
  input  logic pixel_clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic clear,
  output logic flip,
  output logic last
);
  localparam logic [CNT_W-1:0] POSE_MAX = CNT_W'(FRAMES_PER_POSE - 1);
  localparam logic [CNT_W-1:0] FLIP_MAX = CNT_W'(EAT_FLIPS - 1);

  logic [CNT_W-1:0] pose_cnt_q, pose_cnt_d;
  logic [CNT_W-1:0] flip_cnt_q, flip_cnt_d;

  always_comb begin
    flip       = frame_tick && (pose_cnt_q == POSE_MAX);
    last       = flip && (flip_cnt_q == FLIP_MAX);
    pose_cnt_d = pose_cnt_q;
    flip_cnt_d = flip_cnt_q;
    if (clear) begin
      pose_cnt_d = '0;
      flip_cnt_d = '0;
    end else if (frame_tick) begin
      pose_cnt_d = flip ? '0 : pose_cnt_q + 1'b1;
      if (flip) flip_cnt_d = flip_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      pose_cnt_q <= '0;
      flip_cnt_q <= '0;
    end else begin
      pose_cnt_q <= pose_cnt_d;
      flip_cnt_q <= flip_cnt_d;
    end
  end
endmodule

// File: rtl/eat_sequencer.sv
// Eat-scene sequencer: walks the dog down to EAT_Y, alternates eat poses, then finishes.
// EAT_SEQ_RETURN_EN adds a RETURN phase that walks the dog back up to START_Y before DONE.
module eat_sequencer
  import eat_seq_pkg::*;
#(
  parameter logic [X_W-1:0] X1              = 10'd256,
  parameter logic [Y_W-1:0] START_Y         = 9'd400,
  parameter logic [Y_W-1:0] EAT_Y           = 9'd208,
  parameter int unsigned    STEP            = 4,
  parameter int unsigned    FRAMES_PER_POSE = 8,
  parameter int unsigned    EAT_FLIPS       = 6
) (
  input  logic           pixel_clk,
  input  logic           rst,
  input  logic           frame_tick,
  input  logic           eat_req,
  input  logic           cancel,
  output logic           ActionS,
  output logic           run,
  output logic [X_W-1:0] DogPos_x1,
  output logic [X_W-1:0] DogPos_x2,
  output logic [Y_W-1:0] DogPos_y,
  output logic           busy,
  output logic           eat_done
);
  // Compare against limit before subtracting so the 9-bit position never wraps.
  localparam logic [Y_W:0]   WALK_LIM = (Y_W+1)'(EAT_Y) + (Y_W+1)'(STEP);
  localparam logic [Y_W-1:0] STEP_Y   = Y_W'(STEP);

  state_t         state_q, state_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           action_q, action_d;
  logic           run_q, run_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           eat_tick, pose_flip, pose_last;

  assign eat_tick = frame_tick && (state_q == S_EAT) && !cancel;

  eat_pose_timer #(
    .FRAMES_PER_POSE(FRAMES_PER_POSE),
    .EAT_FLIPS      (EAT_FLIPS)
  ) u_pose_timer (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .frame_tick(eat_tick),
    .clear     (state_q != S_EAT),
    .flip      (pose_flip),
    .last      (pose_last)
  );

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    action_d = action_q;
    run_d    = run_q;
    done_d   = 1'b0;
    if (cancel && (state_q == S_WALK || state_q == S_EAT || state_q == S_RETURN)) begin
      state_d  = S_IDLE;
      y_d      = START_Y;
      action_d = 1'b0;
      run_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (eat_req && !cancel) begin
            state_d = S_WALK;
            y_d     = START_Y;
            run_d   = 1'b1;
          end
        end
        S_WALK: begin
          if (frame_tick) begin
            if ({1'b0, y_q} > WALK_LIM) begin
              y_d = y_q - STEP_Y;
            end else begin
              y_d      = EAT_Y;
              state_d  = S_EAT;
              run_d    = 1'b0;
              action_d = 1'b0;
            end
          end
        end
        S_EAT: begin
          if (pose_last) begin
            action_d = 1'b0;
`ifdef EAT_SEQ_RETURN_EN
            state_d  = S_RETURN;
            run_d    = 1'b1;
`else
            state_d  = S_DONE;
            done_d   = 1'b1;
`endif
          end else if (pose_flip) begin
            action_d = ~action_q;
          end
        end
`ifdef EAT_SEQ_RETURN_EN
        S_RETURN: begin
          if (frame_tick) begin
            if (({1'b0, y_q} + (Y_W+1)'(STEP)) < {1'b0, START_Y}) begin
              y_d = y_q + STEP_Y;
            end else begin
              y_d     = START_Y;
              state_d = S_DONE;
              run_d   = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
`endif
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      y_q      <= START_Y;
      action_q <= 1'b0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      action_q <= action_d;
      run_q    <= run_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ActionS   = action_q;
  assign run       = run_q;
  assign busy      = busy_q;
  assign eat_done  = done_q;
  assign DogPos_y  = y_q;
  assign DogPos_x1 = X1;
  assign DogPos_x2 = X1 + X_W'(TILE_W);
endmodule

// File: tb/tb_eat_sequencer.sv
// Random-stimulus bench: STEP=4 and STEP=5 sequencers against a phase/tick-count reference model.
module tb_eat_sequencer;
  localparam int START = 400;
  localparam int EATY  = 208;
  localparam int FPP   = 8;
  localparam int FLIPS = 6;
`ifdef EAT_SEQ_RETURN_EN
  localparam bit RET = 1'b1;
`else
  localparam bit RET = 1'b0;
`endif
  localparam int P_IDLE = 0, P_WALK = 1, P_EAT = 2, P_RET = 3, P_DONE = 4;
  localparam int N_CYC   = 20000;
  localparam int PHASE_B = 4000;

  logic       pixel_clk = 1'b0;
  logic       rst, frame_tick, eat_req, cancel;
  logic [1:0] act_o, run_o, busy_o, done_o;
  logic [9:0] x1_0, x2_0, x1_1, x2_1;
  logic [8:0] y_0, y_1;

  always #5 pixel_clk = ~pixel_clk;

  eat_sequencer u_dut4 (
    .pixel_clk(pixel_clk), .rst(rst), .frame_tick(frame_tick), .eat_req(eat_req),
    .cancel(cancel), .ActionS(act_o[0]), .run(run_o[0]), .DogPos_x1(x1_0),
    .DogPos_x2(x2_0), .DogPos_y(y_0), .busy(busy_o[0]), .eat_done(done_o[0])
  );

  eat_sequencer #(.STEP(5)) u_dut5 (
    .pixel_clk(pixel_clk), .rst(rst), .frame_tick(frame_tick), .eat_req(eat_req),
    .cancel(cancel), .ActionS(act_o[1]), .run(run_o[1]), .DogPos_x1(x1_1),
    .DogPos_x2(x2_1), .DogPos_y(y_1), .busy(busy_o[1]), .eat_done(done_o[1])
  );

  int n_vec = 0;
  int n_err = 0;
  int m_phase[2], m_ticks[2], m_yidle[2], m_scenes[2];
  int m_step[2] = '{4, 5};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_y(input int k);
    case (m_phase[k])
      P_IDLE:  return m_yidle[k];
      P_WALK:  return START - m_step[k] * m_ticks[k];
      P_EAT:   return EATY;
      P_RET:   return EATY + m_step[k] * m_ticks[k];
      default: return RET ? START : EATY;
    endcase
  endfunction

  // {ActionS, run, busy, eat_done}
  function automatic logic [3:0] exp_flags(input int k);
    case (m_phase[k])
      P_WALK:  return 4'b0110;
      P_EAT:   return {((m_ticks[k] / FPP) % 2) == 1, 3'b010};
      P_RET:   return 4'b0110;
      P_DONE:  return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_step(input int k);
    if (rst) begin
      m_phase[k] = P_IDLE;
      m_ticks[k] = 0;
      m_yidle[k] = START;
    end else if (cancel && (m_phase[k] == P_WALK || m_phase[k] == P_EAT || m_phase[k] == P_RET)) begin
      m_phase[k] = P_IDLE;
      m_yidle[k] = START;
    end else begin
      case (m_phase[k])
        P_IDLE: if (eat_req && !cancel) begin
          m_phase[k] = P_WALK;
          m_ticks[k] = 0;
        end
        P_WALK: if (frame_tick) begin
          m_ticks[k]++;
          if (START - m_step[k] * m_ticks[k] <= EATY) begin
            m_phase[k] = P_EAT;
            m_ticks[k] = 0;
          end
        end
        P_EAT: if (frame_tick) begin
          m_ticks[k]++;
          if (m_ticks[k] == FPP * FLIPS) begin
            m_ticks[k] = 0;
            if (RET) m_phase[k] = P_RET;
            else begin
              m_phase[k] = P_DONE;
              m_scenes[k]++;
            end
          end
        end
        P_RET: if (frame_tick) begin
          m_ticks[k]++;
          if (EATY + m_step[k] * m_ticks[k] >= START) begin
            m_phase[k] = P_DONE;
            m_scenes[k]++;
          end
        end
        default: begin
          m_phase[k] = P_IDLE;
          m_yidle[k] = RET ? START : EATY;
        end
      endcase
    end
  endtask

  initial begin
    int  gap;
    bit  did_rst, did_cancel;
    gap = 2;
    did_rst = 1'b0;
    did_cancel = 1'b0;
    rst = 1'b1;
    frame_tick = 1'b0;
    eat_req = 1'b0;
    cancel = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = P_IDLE;
      m_ticks[k] = 0;
      m_yidle[k] = START;
      m_scenes[k] = 0;
    end
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge pixel_clk);
      if (cyc > 0) begin
        check_val("s4 DogPos_y", 32'(y_0), 32'(exp_y(0)));
        check_val("s4 {ActionS,run,busy,eat_done}",
                  32'({act_o[0], run_o[0], busy_o[0], done_o[0]}), 32'(exp_flags(0)));
        check_val("s5 DogPos_y", 32'(y_1), 32'(exp_y(1)));
        check_val("s5 {ActionS,run,busy,eat_done}",
                  32'({act_o[1], run_o[1], busy_o[1], done_o[1]}), 32'(exp_flags(1)));
      end
      rst = (cyc < 3);
      if (!did_rst && m_scenes[0] >= 1 && m_phase[0] == P_WALK && exp_y(0) == 300) begin
        rst = 1'b1;
        did_rst = 1'b1;
      end
      if (cyc >= PHASE_B && $urandom_range(0, 2999) == 0) rst = 1'b1;
      if (gap == 0) begin
        frame_tick = 1'b1;
        gap = $urandom_range(1, 4);
      end else begin
        frame_tick = 1'b0;
        gap--;
      end
      eat_req = ($urandom_range(0, 5) == 0);
      cancel = 1'b0;
      if (!did_cancel && m_scenes[0] >= 2 && m_phase[0] == P_EAT && m_ticks[0] == 3) begin
        cancel = 1'b1;
        did_cancel = 1'b1;
      end
      if (cyc >= PHASE_B && $urandom_range(0, 149) == 0) cancel = 1'b1;
      @(posedge pixel_clk);
      model_step(0);
      model_step(1);
    end
    @(negedge pixel_clk);
    check_val("DogPos_x1", 32'(x1_0), 32'd256);
    check_val("DogPos_x2", 32'(x2_0), 32'd320);
    check_val("s5 DogPos_x2", 32'(x2_1), 32'd320);
    check_val("directed rst/cancel reached", 32'({did_rst, did_cancel}), 32'b11);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
